// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Define DMEM_ARB_STATS_EN to add the saturating grant/conflict statistics counters.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conflict
`endif
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitrate and latch on the next edge
    // ACCESS | latched access driven to memory for one cycle
    // RESP   | ack pulse to the selected port, read data already registered
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              sel_q,        sel_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] p0_rdata_q,   p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q,   p1_rdata_d;

    logic any_req;
    logic both_req;
    logic grant;

    assign any_req  = p0_req | p1_req;
    assign both_req = p0_req & p1_req;
    // On a conflict the port that did not win last time gets the grant.
    assign grant    = both_req ? ~last_grant_q : p1_req;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    sel_d        = grant;
                    last_grant_d = grant;
                    we_d         = grant ? p1_we    : p0_we;
                    addr_d       = grant ? p1_addr  : p0_addr;
                    wdata_d      = grant ? p1_wdata : p0_wdata;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    if (sel_q) p1_rdata_d = mem_rdata;
                    else       p0_rdata_d = mem_rdata;
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // mem_we decodes straight from state so an async reset drops it immediately.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == S_ACCESS) & we_q;
    assign p0_ack    = (state_q == S_RESP) & ~sel_q;
    assign p1_ack    = (state_q == S_RESP) &  sel_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign busy      = (state_q != S_IDLE);

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] gnt0_q, gnt0_d;
    logic [STAT_W-1:0] gnt1_q, gnt1_d;
    logic [STAT_W-1:0] conf_q, conf_d;
    logic              idle_grant;

    assign idle_grant = (state_q == S_IDLE) & any_req;

    always_comb begin
        gnt0_d = gnt0_q;
        gnt1_d = gnt1_q;
        conf_d = conf_q;
        if (idle_grant && !grant && gnt0_q != {STAT_W{1'b1}}) gnt0_d = gnt0_q + STAT_W'(1);
        if (idle_grant &&  grant && gnt1_q != {STAT_W{1'b1}}) gnt1_d = gnt1_q + STAT_W'(1);
        if ((state_q == S_IDLE) && both_req && conf_q != {STAT_W{1'b1}}) conf_d = conf_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_q <= '0;
            gnt1_q <= '0;
            conf_q <= '0;
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            conf_q <= conf_d;
        end
    end

    assign stat_gnt0     = gnt0_q;
    assign stat_gnt1     = gnt1_q;
    assign stat_conflict = conf_q;
`endif

endmodule
